// File: rtl/aemb_ififo_if.sv
// Instruction wishbone fetch port of the AEMB prefetch buffer.
//
// Handshake: the fetch side raises iwb_stb_o whenever it can take a word;
// a word transfers on every rising clock edge where iwb_stb_o and iwb_ack_i
// are both high, with iwb_dat_i valid in that same cycle. An ack while the
// strobe is low is ignored.
interface aemb_ififo_if;
  logic        iwb_stb_o;
  logic        iwb_ack_i;
  logic [31:0] iwb_dat_i;

  // fetch unit side (drives the request)
  modport master (output iwb_stb_o, input iwb_ack_i, input iwb_dat_i);
  // memory side (answers the request)
  modport slave  (input iwb_stb_o, output iwb_ack_i, output iwb_dat_i);
endinterface

// File: rtl/aemb_ififo.sv
// aemb_ififo: instruction prefetch FIFO and decode field extraction.
// Optional macro AEMB_IBUF_BYPASS_EN: when defined, a word acked into an
// empty FIFO while the pipeline advances goes straight to the decode regs.
module aemb_ififo #(
  parameter int          DEPTH = 4,
  parameter int          AW    = 2,
  parameter logic [31:0] NOP   = 32'h88000000
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          rBRA,
  input  logic [1:0]    rXCE,
  aemb_ififo_if.master  iwb,
  output logic [5:0]    rOPC,
  output logic [4:0]    rRD,
  output logic [4:0]    rRA,
  output logic [15:0]   rIMM,
  output logic [4:0]    rRB,
  output logic [10:0]   rALT,
  output logic [31:0]   rSIMM,
  output logic          rVLD,
  output logic [AW:0]   rLVL
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wPtr, rPtr;
  logic [AW:0]   count;
  logic [31:0]   dWord;
  logic          immFlag;
  logic [15:0]   immHi;

  logic        flush, ackIn, doPop, doPush, doBypass, doLoad;
  logic [31:0] ldWord;
  logic [31:0] ldSimm;

  // Request/ack qualification and the per-cycle FIFO actions.
  always_comb begin
    iwb.iwb_stb_o = !grst && (count != FULL);
    flush         = gena && (rBRA || (|rXCE));
    ackIn         = iwb.iwb_stb_o && iwb.iwb_ack_i;
    doPop         = gena && !flush && (count != '0);
`ifdef AEMB_IBUF_BYPASS_EN
    doBypass      = gena && !flush && (count == '0) && ackIn;
`else
    doBypass      = 1'b0;
`endif
    doPush        = ackIn && !flush && !doBypass;
    doLoad        = doPop || doBypass;
    ldWord        = doBypass ? iwb.iwb_dat_i : mem[rPtr];
    // a pending IMM prefix supplies the upper half, otherwise sign-extend
    ldSimm        = immFlag ? {immHi, ldWord[15:0]}
                            : {{16{ldWord[15]}}, ldWord[15:0]};
  end

  // FIFO storage write; no reset needed since occupancy gates every read.
  always_ff @(posedge gclk) begin
    if (!grst && doPush) mem[wPtr] <= iwb.iwb_dat_i;
  end

  // Pointers and occupancy; flush discards everything including a same-cycle ack.
  always_ff @(posedge gclk) begin
    if (grst || flush) begin
      wPtr  <= '0;
      rPtr  <= '0;
      count <= '0;
    end else begin
      if (doPush) wPtr <= wPtr + 1'b1;
      if (doPop)  rPtr <= rPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Decode registers and IMM prefix latch; everything holds while gena=0.
  always_ff @(posedge gclk) begin
    if (grst) begin
      dWord   <= '0;
      rSIMM   <= '0;
      rVLD    <= 1'b0;
      immFlag <= 1'b0;
      immHi   <= '0;
    end else if (gena) begin
      if (flush) begin
        dWord   <= NOP;
        rSIMM   <= '0;
        rVLD    <= 1'b0;
        immFlag <= 1'b0;
      end else if (doLoad) begin
        dWord   <= ldWord;
        rSIMM   <= ldSimm;
        rVLD    <= 1'b1;
        immFlag <= (ldWord[31:26] == 6'o54);
        if (ldWord[31:26] == 6'o54) immHi <= ldWord[15:0];
      end else begin
        // bubble: the IMM latch survives so a prefix can span an empty cycle
        dWord   <= NOP;
        rSIMM   <= '0;
        rVLD    <= 1'b0;
      end
    end
  end

  // Field extraction from the registered decode word.
  always_comb begin
    rOPC = dWord[31:26];
    rRD  = dWord[25:21];
    rRA  = dWord[20:16];
    rIMM = dWord[15:0];
    rRB  = dWord[15:11];
    rALT = dWord[10:0];
    rLVL = count;
  end

endmodule

// File: tb/tb_aemb_ififo.sv
// Directed bench for aemb_ififo (DEPTH=4); bypass expectations follow
// AEMB_IBUF_BYPASS_EN when it is defined for the build.
module tb_aemb_ififo;

  localparam logic [31:0] NOP_W = 32'h88000000;

  logic        gclk = 1'b0;
  logic        grst = 1'b1;
  logic        gena = 1'b0;
  logic        rBRA = 1'b0;
  logic [1:0]  rXCE = 2'b00;
  logic [5:0]  rOPC;
  logic [4:0]  rRD, rRA, rRB;
  logic [15:0] rIMM;
  logic [10:0] rALT;
  logic [31:0] rSIMM;
  logic        rVLD;
  logic [2:0]  rLVL;

  aemb_ififo_if iwb ();

  aemb_ififo #(.DEPTH(4), .AW(2), .NOP(NOP_W)) dut (
    .gclk(gclk), .grst(grst), .gena(gena), .rBRA(rBRA), .rXCE(rXCE),
    .iwb(iwb.master),
    .rOPC(rOPC), .rRD(rRD), .rRA(rRA), .rIMM(rIMM), .rRB(rRB), .rALT(rALT),
    .rSIMM(rSIMM), .rVLD(rVLD), .rLVL(rLVL)
  );

  // clock
  always #5 gclk = ~gclk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        gena;
    logic        bra;
    logic [1:0]  xce;
    logic        ack;
    logic [31:0] dat;
    logic        vld;
    logic [31:0] word;
    logic [31:0] simm;
    logic [2:0]  lvl;
    logic        stb;
  } vec_t;

  vec_t vecs[$];

  // expected decode state carried from row to row while building the table
  logic [31:0] cur_word = 32'h0;
  logic [31:0] cur_simm = 32'h0;
  logic        cur_vld  = 1'b0;

  function automatic void add_row(input logic g, input logic b, input logic [1:0] x,
                                  input logic a, input logic [31:0] d, input logic [2:0] l);
    vec_t t;
    t.gena = g; t.bra = b; t.xce = x; t.ack = a; t.dat = d;
    t.vld = cur_vld; t.word = cur_word; t.simm = cur_simm;
    t.lvl = l; t.stb = (l != 3'd4);
    vecs.push_back(t);
  endfunction

  // decode regs unchanged
  function automatic void row_hold(input logic g, input logic b, input logic [1:0] x,
                                   input logic a, input logic [31:0] d, input logic [2:0] l);
    add_row(g, b, x, a, d, l);
  endfunction

  // decode regs take word w with resolved immediate s
  function automatic void row_load(input logic g, input logic b, input logic [1:0] x,
                                   input logic a, input logic [31:0] d, input logic [31:0] w,
                                   input logic [31:0] s, input logic [2:0] l);
    cur_word = w; cur_simm = s; cur_vld = 1'b1;
    add_row(g, b, x, a, d, l);
  endfunction

  // decode regs take the NOP bubble
  function automatic void row_bub(input logic g, input logic b, input logic [1:0] x,
                                  input logic a, input logic [31:0] d, input logic [2:0] l);
    cur_word = NOP_W; cur_simm = 32'h0; cur_vld = 1'b0;
    add_row(g, b, x, a, d, l);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, " vld"},  32'(rVLD),  32'(v.vld));
    chk({tag, " opc"},  32'(rOPC),  32'(v.word[31:26]));
    chk({tag, " rd"},   32'(rRD),   32'(v.word[25:21]));
    chk({tag, " ra"},   32'(rRA),   32'(v.word[20:16]));
    chk({tag, " imm"},  32'(rIMM),  32'(v.word[15:0]));
    chk({tag, " rb"},   32'(rRB),   32'(v.word[15:11]));
    chk({tag, " alt"},  32'(rALT),  32'(v.word[10:0]));
    chk({tag, " simm"}, rSIMM,      v.simm);
    chk({tag, " lvl"},  32'(rLVL),  32'(v.lvl));
    chk({tag, " stb"},  32'(iwb.iwb_stb_o), 32'(v.stb));
  endtask

  task automatic apply(input vec_t v);
    @(negedge gclk);
    gena = v.gena; rBRA = v.bra; rXCE = v.xce;
    iwb.iwb_ack_i = v.ack; iwb.iwb_dat_i = v.dat;
    @(posedge gclk);
    #1;
  endtask

  initial begin
    vec_t zero_v;
    iwb.iwb_ack_i = 1'b0;
    iwb.iwb_dat_i = 32'h0;

    // fill with pipeline stalled; fifth ack is refused while full
    row_hold(1, 0, 0, 1, 32'h30600005, 3'd1);
    vecs[0].gena = 1'b0;
    row_hold(0, 0, 0, 1, 32'h30600006, 3'd2);
    row_hold(0, 0, 0, 1, 32'h30600007, 3'd3);
    row_hold(0, 0, 0, 1, 32'h30600008, 3'd4);
    row_hold(0, 0, 0, 1, 32'h30600009, 3'd4);
    // drain in order
    row_load(1, 0, 0, 0, 32'h0, 32'h30600005, 32'h5, 3'd3);
    row_load(1, 0, 0, 0, 32'h0, 32'h30600006, 32'h6, 3'd2);
    row_load(1, 0, 0, 0, 32'h0, 32'h30600007, 32'h7, 3'd1);
    row_load(1, 0, 0, 0, 32'h0, 32'h30600008, 32'h8, 3'd0);
    row_bub (1, 0, 0, 0, 32'h0, 3'd0);
    // IMM prefix across a bubble, then a plain word sign-extends
    row_hold(0, 0, 0, 1, 32'hB0001234, 3'd1);
    row_load(1, 0, 0, 0, 32'h0, 32'hB0001234, 32'h00001234, 3'd0);
    row_bub (1, 0, 0, 0, 32'h0, 3'd0);
    row_hold(0, 0, 0, 1, 32'h3060FFF0, 3'd1);
    row_load(1, 0, 0, 0, 32'h0, 32'h3060FFF0, 32'h1234FFF0, 3'd0);
    row_hold(0, 0, 0, 1, 32'h3060FFF0, 3'd1);
    row_load(1, 0, 0, 0, 32'h0, 32'h3060FFF0, 32'hFFFFFFF0, 3'd0);
    // ack into an empty FIFO while advancing
`ifdef AEMB_IBUF_BYPASS_EN
    row_load(1, 0, 0, 1, 32'h30600007, 32'h30600007, 32'h7, 3'd0);
    row_bub (1, 0, 0, 0, 32'h0, 3'd0);
`else
    row_bub (1, 0, 0, 1, 32'h30600007, 3'd1);
    row_load(1, 0, 0, 0, 32'h0, 32'h30600007, 32'h7, 3'd0);
`endif
    row_bub (1, 0, 0, 0, 32'h0, 3'd0);
    // branch flush with three words queued, IMM armed and a same-cycle ack
    row_hold(0, 0, 0, 1, 32'hB000ABCD, 3'd1);
    row_hold(0, 0, 0, 1, 32'h3060000B, 3'd2);
    row_hold(0, 0, 0, 1, 32'h3060000C, 3'd3);
    row_load(1, 0, 0, 0, 32'h0, 32'hB000ABCD, 32'hFFFFABCD, 3'd2);
    row_hold(0, 0, 0, 1, 32'h3060000D, 3'd3);
    row_bub (1, 1, 0, 1, 32'h3060000E, 3'd0);
    row_hold(0, 0, 0, 1, 32'h3060000F, 3'd1);
    row_load(1, 0, 0, 0, 32'h0, 32'h3060000F, 32'h0000000F, 3'd0);
    // exception waits for gena
    row_hold(0, 0, 0, 1, 32'h30600010, 3'd1);
    row_hold(0, 0, 2'b01, 1, 32'h30600011, 3'd2);
    row_bub (1, 0, 2'b01, 0, 32'h0, 3'd0);
    row_bub (1, 0, 0, 0, 32'h0, 3'd0);
    // simultaneous pop and push keeps the level
    row_hold(0, 0, 0, 1, 32'h30650012, 3'd1);
    row_load(1, 0, 0, 1, 32'h3061F813, 32'h30650012, 32'h12, 3'd1);
    row_load(1, 0, 0, 0, 32'h0, 32'h3061F813, 32'hFFFFF813, 3'd0);

    // reset: two cycles held, then released
    zero_v = '{gena: 1'b0, bra: 1'b0, xce: 2'b0, ack: 1'b0, dat: 32'h0,
               vld: 1'b0, word: 32'h0, simm: 32'h0, lvl: 3'd0, stb: 1'b0};
    repeat (2) @(posedge gclk);
    #1;
    check_outputs("reset", zero_v);
    @(negedge gclk);
    grst = 1'b0;
    #1;
    chk("stb after reset", 32'(iwb.iwb_stb_o), 32'h1);

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k]);
      check_outputs($sformatf("row%0d", k), vecs[k]);
    end

    // reset mid-stream with data queued
    @(negedge gclk);
    gena = 1'b0; iwb.iwb_ack_i = 1'b1; iwb.iwb_dat_i = 32'h30600020;
    @(posedge gclk);
    #1;
    chk("queued before reset lvl", 32'(rLVL), 32'h1);
    @(negedge gclk);
    grst = 1'b1;
    #1;
    chk("stb during reset", 32'(iwb.iwb_stb_o), 32'h0);
    @(posedge gclk);
    #1;
    check_outputs("rereset", zero_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aemb_ififo.md
Name: aemb_ififo

Overview:
- Parametrised instruction prefetch buffer for the AEMB core.
- Decouples the instruction wishbone port from the decode stage with a DEPTH-entry FIFO. Fetched words are accepted whenever the bus acks, even while the pipeline is stalled.
- Decodes the head word into opcode/register/immediate fields and builds the sign-extended or IMM-prefixed 32-bit immediate.
- Sits between the instruction bus and the control/decode stage; inserts NOP bubbles on empty, branch or exception.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..32
AW, 2, pointer width, log2(DEPTH)
NOP, 32'h88000000, word injected into decode on bubble/flush

Ports:
gclk  in  1  clock
grst  in  1  synchronous active-high reset
gena  in  1  pipeline advance enable
rBRA  in  1  branch taken, flush request
rXCE  in  2  exception/interrupt pending, flush if nonzero
iwb_stb_o  out  1  fetch request
iwb_ack_i  in  1  fetch acknowledge, data valid
iwb_dat_i  in  32  fetched instruction
rOPC  out  6  decode opcode [31:26]
rRD  out  5  destination [25:21]
rRA  out  5  source A [20:16]
rIMM  out  16  immediate [15:0]
rRB  out  5  rIMM[15:11]
rALT  out  11  rIMM[10:0]
rSIMM  out  32  resolved 32-bit immediate
rVLD  out  1  1 = decode regs hold a fetched instruction, 0 = bubble
rLVL  out  AW+1  current FIFO occupancy

Behaviour:
- Reset (grst=1 at posedge):
  - Pointers and count cleared.
  - All decode outputs zero; rVLD=0; IMM latch cleared.
  - iwb_stb_o forced 0 while grst=1.
- iwb_stb_o = !grst & (count != DEPTH). Combinational, no in-flight counting.
- Push: on a posedge with iwb_stb_o & iwb_ack_i, write iwb_dat_i at the write pointer. Pointers wrap modulo DEPTH.
  - Push is independent of gena; the FIFO keeps filling while the pipeline stalls.
- Flush: flush = rBRA | (|rXCE), sampled only when gena=1.
  - Count and pointers cleared.
  - An ack in the same cycle is discarded.
  - Decode regs load NOP; rVLD=0; IMM latch cleared.
  - Flush has priority over pop and push.
- Pop: when gena=1, no flush and count>0.
  - Head word loads {rOPC,rRD,rRA,rIMM}; read pointer advances; rVLD=1.
  - Load latency is one cycle.
- Empty with gena=1 and no flush: decode regs load NOP, rVLD=0.
  - Without AEMB_IBUF_BYPASS_EN, a same-cycle ack goes into the FIFO.
- gena=0: decode regs, rSIMM, rVLD and IMM latch hold. Push still permitted.
- Count update: pop and push in the same cycle leaves count unchanged. Push cannot occur when full.
- IMM handling:
  - When a valid word with opcode 6'o54 is loaded, set the IMM latch: flag=1, hi=word[15:0].
  - The latch persists across NOP bubbles.
  - rSIMM for the next valid loaded word = flag ? {hi, word[15:0]} : sign-extend word[15:0].
  - Loading any valid non-IMM word clears the flag; an IMM word re-arms it.
  - Bubbles load rSIMM = 32'h0 and do not touch the latch.
- rLVL reflects the count after the current edge (registered).

Optional Feature:
AEMB_IBUF_BYPASS_EN
- Defined: when the FIFO is empty, gena=1, no flush and ack=1, iwb_dat_i loads decode directly (rVLD=1). The word is not written to the FIFO, giving zero-cycle buffer latency.
- Undefined: the word is always written to the FIFO and reaches decode at the earliest on the next gena cycle.

Test Plan:
- Reset: grst=1 for 2 cycles, then 0 → all outputs 0, rVLD=0, rLVL=0, iwb_stb_o=1 on the first cycle after reset.
- Fill with gena=0 and DEPTH=4: ack 4 words 0x30600005.. → rLVL=4, iwb_stb_o=0, 5th ack ignored; raise gena → words emerge in order, rOPC=6'o14, rRD=3, rSIMM=32'h5.
- IMM across a bubble: push 0xB0001234 (IMM), then an idle cycle (empty, gena=1), then 0x3060FFF0 → bubble shows rVLD=0, then rSIMM=32'h1234FFF0, rVLD=1; the next plain 0x3060FFF0 gives rSIMM=32'hFFFFFFF0.
- Flush: FIFO holds 3 words, rBRA=1 with gena=1 and ack=1 in the same cycle → next cycle rLVL=0, rOPC=6'o42 (NOP), rVLD=0, IMM latch clear.
- Exception: rXCE=2'b01 with gena=0 → no flush; hold state; flush occurs on the first cycle gena=1.
- Bypass (macro defined): empty FIFO, gena=1, ack with 0x30600007 → same edge loads decode, rVLD=1, rLVL stays 0; without the macro, rLVL=1 and rVLD=0 that cycle.
